// File: rtl/csa_accum_if.sv
// csa_accum_if: operand-in / result-out handshake bundle for csa_accum.
//   in_valid/in_ready/in_data/in_last : operand beat stream into the accumulator
//   out_valid/out_ready/out_sum/out_ovf : resolved packet result stream
// Modports:
//   master : the operand source / result consumer side
//   slave  : the accumulator side
interface csa_accum_if #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/csa_accum.sv
// csa_accum: multi-operand carry-save accumulator.
// Operand beats are folded into a redundant sum/carry pair by one row of
// full-adder cells per beat. On the last beat of a packet, a chunked
// carry-propagate adder resolves the pair CHUNK bits per cycle, and the
// binary result is presented on the output handshake.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : csa_accum_if.slave (in_valid/in_ready/in_data/in_last,
//           out_valid/out_ready/out_sum/out_ovf)
//   busy  : high while resolving or holding a result
// Optional build macro:
//   CSA_ACC_SAT_EN : saturate out_sum to all ones when the packet overflowed
module csa_accum #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 24,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  csa_accum_if.slave   bus,
  output logic         busy
);

  localparam int NCHUNK = ACC_W / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_RESOLVE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] s;
  logic [ACC_W-1:0] c;
  logic [ACC_W-1:0] result;
  logic [KW-1:0]    k;
  logic             cy;
  logic             ovf;
  logic             out_valid_r;
  logic [ACC_W-1:0] out_sum_r;
  logic             out_ovf_r;

  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] maj;
  logic             accept;
  int               lsb;
  logic [CHUNK-1:0] s_chk;
  logic [CHUNK-1:0] c_chk;
  logic [CHUNK:0]   csum;
  logic [ACC_W-1:0] res_next;
  logic             last_chunk;
  logic             ovf_fin;
  logic [ACC_W-1:0] out_next;

  assign bus.in_ready  = (state == ST_ACCUM);
  assign busy          = (state != ST_ACCUM);
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_ovf   = out_ovf_r;

  assign accept = bus.in_valid & bus.in_ready;
  assign x      = ACC_W'(bus.in_data);
  assign maj    = (s & c) | (x & (s | c));

  // One chunk of the carry-propagate adder; the chunk carry ripples
  // between cycles through cy.
  always_comb begin
    lsb        = int'(k) * CHUNK;
    s_chk      = s[lsb +: CHUNK];
    c_chk      = c[lsb +: CHUNK];
    csum       = {1'b0, s_chk} + {1'b0, c_chk} + {{CHUNK{1'b0}}, cy};
    res_next   = result;
    res_next[lsb +: CHUNK] = csum[CHUNK-1:0];
    last_chunk = (k == KW'(NCHUNK - 1));
    ovf_fin    = ovf | csum[CHUNK];
  end

`ifdef CSA_ACC_SAT_EN
  assign out_next = ovf_fin ? {ACC_W{1'b1}} : res_next;
`else
  assign out_next = res_next;
`endif

  // The carry leaving the top cell of the CSA row has no home in the
  // ACC_W-bit pair; since S and C are never negative, losing it means the
  // true total already reached 2^ACC_W, so it feeds the sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ACCUM;
      s           <= '0;
      c           <= '0;
      result      <= '0;
      k           <= '0;
      cy          <= 1'b0;
      ovf         <= 1'b0;
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_ovf_r   <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            s   <= s ^ c ^ x;
            c   <= {maj[ACC_W-2:0], 1'b0};
            ovf <= ovf | maj[ACC_W-1];
            if (bus.in_last) begin
              state <= ST_RESOLVE;
              k     <= '0;
              cy    <= 1'b0;
            end
          end
        end
        ST_RESOLVE: begin
          result <= res_next;
          cy     <= csum[CHUNK];
          k      <= k + 1'b1;
          if (last_chunk) begin
            k           <= '0;
            ovf         <= ovf_fin;
            state       <= ST_DONE;
            out_valid_r <= 1'b1;
            out_sum_r   <= out_next;
            out_ovf_r   <= ovf_fin;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            s           <= '0;
            c           <= '0;
            ovf         <= 1'b0;
            out_valid_r <= 1'b0;
            state       <= ST_ACCUM;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: doc/csa_accum.md
Name: csa_accum

Overview:
- Multi-operand accumulator for the carry-save arithmetic path.
- Holds a running total as a redundant sum/carry vector pair, updated each beat by a row of full-adder sum and majority-carry cells.
- On the last beat of a packet, a chunked multi-cycle carry-propagate adder turns the pair into a binary result.
- Sits downstream of operand generation and feeds the result register stage.

Parameters:
- WIDTH, 16, input operand width (unsigned).
- ACC_W, 24, accumulator and result width; ACC_W >= WIDTH; ACC_W is a multiple of CHUNK.
- CHUNK, 8, bits resolved per cycle by the final carry-propagate adder; NCHUNK = ACC_W/CHUNK.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat.
- in_data  input  WIDTH  unsigned operand, zero-extended to ACC_W.
- in_last  input  1  final beat of packet; sampled with in_data.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  ACC_W  packet sum.
- out_ovf  output  1  true sum >= 2^ACC_W.
- busy  output  1  high in RESOLVE or DONE.

Behaviour:
- One clock domain. rst_n asserts asynchronously and releases synchronously to clk.
- Reset values:
  - State = ACCUM; S, C, result, chunk counter, carry register and ovf all 0.
  - out_valid 0, out_sum 0, out_ovf 0, busy 0, in_ready 1.
- States: ACCUM -> RESOLVE -> DONE -> ACCUM.
- ACCUM:
  - in_ready = 1.
  - A beat is accepted when in_valid & in_ready at a clock edge.
  - With X = in_data zero-extended: S' = S ^ C ^ X.
  - C' = {maj(S,C,X)[ACC_W-2:0], 1'b0}, where maj = a&b | c&(a|b).
  - The dropped bit maj[ACC_W-1] ORs into sticky ovf.
  - in_last accepted -> RESOLVE, chunk counter k = 0, carry register = 0.
  - in_last low -> stay in ACCUM.
  - Gaps between beats (in_valid low) are allowed and leave S/C unchanged.
- RESOLVE:
  - in_ready = 0.
  - Each cycle: {cy, result[k]} = S[k] + C[k] + cy, where [k] denotes chunk k (CHUNK bits). Then k increments.
  - After chunk NCHUNK-1: the final cy ORs into ovf, and the state goes to DONE.
  - Latency: out_valid rises exactly NCHUNK cycles after the edge accepting the last beat (3 at defaults).
- DONE:
  - out_valid = 1; out_sum = result; out_ovf = ovf; in_ready = 0.
  - Outputs are held stable while out_ready is low.
  - On out_valid & out_ready: clear S, C and ovf; go to ACCUM. out_valid falls the next cycle, and in_ready is 1 that cycle.
- Boundary conditions:
  - Single-beat packet (in_last on first beat) is legal.
  - Result is modulo 2^ACC_W.
  - ovf is exact: OR of all dropped accumulate carries and the final CPA carry.
  - in_valid during RESOLVE/DONE is ignored and not consumed; the source must hold the beat.
  - rst_n low mid-packet, in RESOLVE, or in DONE: the packet is discarded and all state returns to reset values immediately.
- Outputs are registered, except in_ready and busy, which decode directly from state.

Optional Feature:
- Macro CSA_ACC_SAT_EN.
- Defined: in DONE, out_sum = {ACC_W{1'b1}} whenever ovf = 1; otherwise the modular result. out_ovf is still reported.
- Undefined: out_sum is always the modular (wrapped) result.
- Latency is identical either way.

Test Plan (WIDTH=16, ACC_W=24, CHUNK=8):
1. Single beat 0x1234 with in_last, out_ready=1 -> out_valid 3 cycles after accept; out_sum=0x001234, out_ovf=0; in_ready 0 throughout.
2. Beats 0xFFFF, 0xFFFF, 0xFFFF (last on third) -> out_sum=0x02FFFD, out_ovf=0.
3. 257 beats of 0xFFFF -> out_ovf=1; out_sum=0x00FEFF without the macro, 0xFFFFFF with CSA_ACC_SAT_EN.
4. Backpressure case:
   - Stimulus: beat 0x0007 last; hold out_ready=0 for 5 cycles while driving in_valid=1 with in_data=0x0009.
   - Response: out_sum=0x000007 held stable; 0x0009 not accepted until out_ready rises.
   - Then 0x0009 last -> out_sum=0x000009 (state cleared).
5. Beat 0x0010, two idle cycles, beat 0x0020 last -> out_sum=0x000030.
6. Reset mid-RESOLVE:
   - Stimulus: assert rst_n=0 one cycle after last-beat accept.
   - Response: out_valid=0, in_ready=1, busy=0 immediately.
   - Then 0x0005 last -> out_sum=0x000005, out_ovf=0.
